mem_responder: RTL and testbench

//  Memory-side responder for the core's single-master bus: answers core reads/writes
//  on mem_addr/mem_mode/mem_wen/mem_dat_o with mem_dat_i and mem_ready.

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Core-to-memory bus bundle for mem_responder.
// The mem_err signal exists only when MEM_RESP_ERR_EN is defined.
interface mem_responder_if;
    logic        mem_wen;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_o;
    logic [31:0] mem_dat_i;
    logic        mem_ready;
`ifdef MEM_RESP_ERR_EN
    logic        mem_err;

    modport master (
        output mem_wen, mem_mode, mem_addr, mem_dat_o,
        input  mem_dat_i, mem_ready, mem_err
    );
    modport slave (
        input  mem_wen, mem_mode, mem_addr, mem_dat_o,
        output mem_dat_i, mem_ready, mem_err
    );
`else
    modport master (
        output mem_wen, mem_mode, mem_addr, mem_dat_o,
        input  mem_dat_i, mem_ready
    );
    modport slave (
        input  mem_wen, mem_mode, mem_addr, mem_dat_o,
        output mem_dat_i, mem_ready
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-organised on-chip RAM responder with byte-lane writes and configurable wait states.
// Optional MEM_RESP_ERR_EN: adds mem_err and returns 32'hDEADBEEF on miss reads.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_WAIT    = 1'b1;
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef MEM_RESP_ERR_EN
    localparam logic [31:0] MISS_RDATA = 32'hDEADBEEF;
`else
    localparam logic [31:0] MISS_RDATA = '0;
`endif

    logic [31:0]       r_mem [DEPTH];

    logic [0:0]        r_state;
    logic              r_req_vld;
    logic              r_wen;
    logic [2:0]        r_mode;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdat;
    logic [3:0]        r_cnt;
    logic [31:0]       r_rdat;
    logic              r_ready;
`ifdef MEM_RESP_ERR_EN
    logic              r_err;
`endif

    logic              w_req_same;
    logic              w_new;
    logic              w_access;
    logic [31:0]       w_offset;
    logic              w_hit;
    logic [ADDR_W-1:0] w_idx;
    logic              w_misal;
    logic [3:0]        w_be;
    logic              w_commit;

    // A request is "new" when it differs from the latched copy or nothing is latched yet.
    assign w_req_same = r_req_vld
                     && (bus.mem_wen   == r_wen)
                     && (bus.mem_mode  == r_mode)
                     && (bus.mem_addr  == r_addr)
                     && (bus.mem_dat_o == r_wdat);
    assign w_new      = !w_req_same;

    always_comb begin
        w_access = 1'b0;
        if (r_state == S_IDLE) begin
            w_access = w_new && (WAIT_CYCLES == 0);
        end else begin
            w_access = w_req_same && (r_cnt == 4'd0);
        end
    end

    assign w_offset = bus.mem_addr - BASE_ADDR;
    assign w_hit    = (bus.mem_addr >= BASE_ADDR) && ({1'b0, w_offset} < WIN_BYTES);
    assign w_idx    = w_offset[ADDR_W+1:2];

    always_comb begin
        w_misal = 1'b0;
        w_be    = 4'b1111;
        case (bus.mem_mode[1:0])
            2'b00: begin
                w_misal = 1'b0;
                w_be    = 4'b0001 << bus.mem_addr[1:0];
            end
            2'b01: begin
                w_misal = bus.mem_addr[0];
                w_be    = 4'b0011 << {bus.mem_addr[1], 1'b0};
            end
            default: begin
                w_misal = |bus.mem_addr[1:0];
                w_be    = 4'b1111;
            end
        endcase
    end

    // Gated by rst so a clock edge during reset (valid latch cleared) never writes.
    assign w_commit = rst && w_access && bus.mem_wen && w_hit && !w_misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_req_vld <= 1'b0;
            r_wen     <= 1'b0;
            r_mode    <= '0;
            r_addr    <= '0;
            r_wdat    <= '0;
            r_cnt     <= '0;
            r_rdat    <= '0;
            r_ready   <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            if (w_new) begin
                r_req_vld <= 1'b1;
                r_wen     <= bus.mem_wen;
                r_mode    <= bus.mem_mode;
                r_addr    <= bus.mem_addr;
                r_wdat    <= bus.mem_dat_o;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_new && (WAIT_CYCLES != 0)) begin
                        r_ready <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    if (w_new) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            if (w_access) begin
                r_ready <= 1'b1;
                r_rdat  <= w_hit ? r_mem[w_idx] : MISS_RDATA;
`ifdef MEM_RESP_ERR_EN
                r_err   <= !w_hit || (bus.mem_wen && w_misal);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.mem_dat_o[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_dat_i = r_rdat;
    assign bus.mem_ready = r_ready;
`ifdef MEM_RESP_ERR_EN
    assign bus.mem_err   = r_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one zero-wait and one 3-wait instance, table vectors,
// hand-written wait/reset sequences and randomized traffic against a reference model.
module tb_mem_responder;

    localparam logic [31:0] BASE  = 32'h80000000;
    localparam int unsigned AW    = 8;
    localparam int unsigned WORDS = 256;
`ifdef MEM_RESP_ERR_EN
    localparam logic [31:0] MISS_RD = 32'hDEADBEEF;
`else
    localparam logic [31:0] MISS_RD = 32'h00000000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus3 ();

    mem_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    mem_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdl [2][WORDS];

    function automatic logic [31:0] fill_val(input int unsigned i);
        return 32'hC0000000 + i * 32'h00010101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: one access on the word-array model, byte masks from size and offset.
    task automatic model_access(input int sel, input logic wen, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] dat,
                                output logic [31:0] rd, output logic err);
        longint      off;
        int unsigned size;
        int unsigned idx;
        logic        hit;
        logic        misal;
        logic [63:0] mk;
        off   = longint'(addr) - longint'(BASE);
        hit   = (off >= 0) && (off < longint'(WORDS * 4));
        idx   = hit ? int'(off / 4) : 0;
        size  = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
        misal = (addr % size) != 0;
        rd    = hit ? mdl[sel][idx] : MISS_RD;
        err   = !hit || (wen && misal);
        if (hit && wen && !misal) begin
            mk = ((64'd1 << (8 * size)) - 64'd1) << (8 * (addr % 4));
            mdl[sel][idx] = (mdl[sel][idx] & ~mk[31:0]) | (dat & mk[31:0]);
        end
    endtask

    task automatic drive(input int sel, input logic wen, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] dat);
        if (sel == 0) begin
            bus0.mem_wen = wen; bus0.mem_mode = mode; bus0.mem_addr = addr; bus0.mem_dat_o = dat;
        end else begin
            bus3.mem_wen = wen; bus3.mem_mode = mode; bus3.mem_addr = addr; bus3.mem_dat_o = dat;
        end
    endtask

    task automatic check_err(input string name, input int sel, input logic exp);
`ifdef MEM_RESP_ERR_EN
        check(name, (sel == 0) ? {31'd0, bus0.mem_err} : {31'd0, bus3.mem_err}, {31'd0, exp});
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, exp_rd, scratch;
        logic        er, exp_err;
        logic [67:0] cur, last;
        logic [2:0]  modes [6];
        logic [31:0] a;
        logic        w;
        logic [2:0]  md;
        logic [31:0] d;
        int unsigned k;

        modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
        drive(0, 1'b0, 3'b010, BASE, '0);
        drive(1, 1'b0, 3'b010, BASE, '0);

        // Reset state, observed without any clock edge.
        #1 rst = 1'b0;
        #2;
        check("rst0_dat", bus0.mem_dat_i, 32'h0);
        check("rst0_rdy", {31'd0, bus0.mem_ready}, 32'h0);
        check("rst3_dat", bus3.mem_dat_i, 32'h0);
        check("rst3_rdy", {31'd0, bus3.mem_ready}, 32'h0);
        check_err("rst0_err", 0, 1'b0);

        @(posedge clk); #1 rst = 1'b1;
        step();
        check("first_rd_rdy", {31'd0, bus0.mem_ready}, 32'h1);

        // Populate both RAMs with a known pattern.
        for (int unsigned i = 0; i < WORDS; i++) begin
            drive(0, 1'b1, 3'b010, BASE + 4 * i, fill_val(i));
            mdl[0][i] = fill_val(i);
            step();
        end
        for (int unsigned i = 0; i < WORDS; i++) begin
            drive(1, 1'b1, 3'b010, BASE + 4 * i, ~fill_val(i));
            mdl[1][i] = ~fill_val(i);
            repeat (4) step();
        end
        check("fill3_rdy", {31'd0, bus3.mem_ready}, 32'h1);

        tbl.push_back('{1'b1, 3'b010, 32'h80000010, 32'h11223344, fill_val(4), 1'b0});
        tbl.push_back('{1'b0, 3'b111, 32'h80000010, 32'h00000000, 32'h11223344, 1'b0});
        tbl.push_back('{1'b1, 3'b000, 32'h80000013, 32'hAB000000, 32'h11223344, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h80000010, 32'h00000000, 32'hAB223344, 1'b0});
        tbl.push_back('{1'b1, 3'b001, 32'h80000012, 32'h55660000, 32'hAB223344, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h80000011, 32'h00000000, 32'h55663344, 1'b0});
        tbl.push_back('{1'b1, 3'b001, 32'h80000011, 32'h99990000, 32'h55663344, 1'b1});
        tbl.push_back('{1'b0, 3'b010, 32'h80000010, 32'h00000000, 32'h55663344, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h00001000, 32'h00000000, MISS_RD, 1'b1});
        tbl.push_back('{1'b1, 3'b010, 32'h80000400, 32'h12345678, MISS_RD, 1'b1});
        tbl.push_back('{1'b0, 3'b010, 32'h800003FC, 32'h00000000, fill_val(255), 1'b0});
        tbl.push_back('{1'b1, 3'b010, 32'h80000002, 32'hFFFFFFFF, fill_val(0), 1'b1});
        tbl.push_back('{1'b0, 3'b010, 32'h80000000, 32'h00000000, fill_val(0), 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h7FFFFFFC, 32'h00000000, MISS_RD, 1'b1});
        tbl.push_back('{1'b1, 3'b100, 32'h80000021, 32'h0000CD00, fill_val(8), 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h80000020, 32'h00000000,
                        (fill_val(8) & 32'hFFFF00FF) | 32'h0000CD00, 1'b0});
        tbl.push_back('{1'b1, 3'b111, 32'h80000024, 32'hCAFEF00D, fill_val(9), 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h80000024, 32'h00000000, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b1, 3'b101, 32'h80000026, 32'hBEEF0000, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h80000024, 32'h00000000, 32'hBEEFF00D, 1'b0});

        foreach (tbl[i]) begin
            drive(0, tbl[i].wen, tbl[i].mode, tbl[i].addr, tbl[i].dat);
            step();
            check($sformatf("tbl%0d_dat", i), bus0.mem_dat_i, tbl[i].exp_rd);
            check($sformatf("tbl%0d_rdy", i), {31'd0, bus0.mem_ready}, 32'h1);
            check_err($sformatf("tbl%0d_err", i), 0, tbl[i].exp_err);
            model_access(0, tbl[i].wen, tbl[i].mode, tbl[i].addr, tbl[i].dat, rd, er);
        end

        // A held write request must commit exactly once.
        drive(0, 1'b1, 3'b010, 32'h80000030, 32'h77777777);
        step();
        check("hold_first", bus0.mem_dat_i, fill_val(12));
        model_access(0, 1'b1, 3'b010, 32'h80000030, 32'h77777777, rd, er);
        repeat (2) step();
        check("hold_repeat", bus0.mem_dat_i, fill_val(12));
        drive(0, 1'b0, 3'b010, 32'h80000030, 32'h0);
        step();
        check("hold_readback", bus0.mem_dat_i, 32'h77777777);
        exp_rd  = 32'h77777777;
        exp_err = 1'b0;
        last    = {1'b0, 3'b010, 32'h80000030, 32'h0};

        // Randomized traffic on the zero-wait instance.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) != 0) begin
                k = $urandom_range(7);
                if (k == 0)      a = $urandom() & 32'h7FFFFFFF;
                else if (k == 1) a = BASE + 32'd1024 + $urandom_range(4095);
                else             a = BASE + $urandom_range(1023);
                w  = 1'($urandom_range(1));
                md = modes[$urandom_range(5)];
                d  = $urandom();
                cur = {w, md, a, d};
            end else begin
                cur = last;
            end
            drive(0, cur[67], cur[66:64], cur[63:32], cur[31:0]);
            step();
            if (cur != last) begin
                model_access(0, cur[67], cur[66:64], cur[63:32], cur[31:0], exp_rd, exp_err);
                last = cur;
            end
            check($sformatf("rnd%0d_dat", n), bus0.mem_dat_i, exp_rd);
            check($sformatf("rnd%0d_rdy", n), {31'd0, bus0.mem_ready}, 32'h1);
            check_err($sformatf("rnd%0d_err", n), 0, exp_err);
        end

        // Wait states: ready low for three edges, completes on the fourth.
        drive(1, 1'b0, 3'b010, 32'h80000010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("waitA_low%0d", i), {31'd0, bus3.mem_ready}, 32'h0);
        end
        step();
        check("waitA_rdy", {31'd0, bus3.mem_ready}, 32'h1);
        check("waitA_dat", bus3.mem_dat_i, mdl[1][4]);

        // Address change mid-wait restarts the count; only the new address answers.
        drive(1, 1'b0, 3'b010, 32'h80000020, 32'h0);
        repeat (2) step();
        check("waitB_low", {31'd0, bus3.mem_ready}, 32'h0);
        drive(1, 1'b0, 3'b010, 32'h80000030, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("waitB_relow%0d", i), {31'd0, bus3.mem_ready}, 32'h0);
        end
        step();
        check("waitB_rdy", {31'd0, bus3.mem_ready}, 32'h1);
        check("waitB_dat", bus3.mem_dat_i, mdl[1][12]);

        // Write with waits returns the old word, then reads back the new one.
        drive(1, 1'b1, 3'b010, 32'h80000050, 32'h13572468);
        repeat (4) step();
        check("waitC_old", bus3.mem_dat_i, mdl[1][20]);
        model_access(1, 1'b1, 3'b010, 32'h80000050, 32'h13572468, rd, er);
        drive(1, 1'b0, 3'b010, 32'h80000050, 32'h0);
        repeat (4) step();
        check("waitC_new", bus3.mem_dat_i, 32'h13572468);

        // Write replaced before completion must not commit.
        drive(1, 1'b1, 3'b010, 32'h80000060, 32'hFFFF0000);
        repeat (2) step();
        drive(1, 1'b0, 3'b010, 32'h80000060, 32'h0);
        repeat (4) step();
        check("abort_dat", bus3.mem_dat_i, mdl[1][24]);
        check("abort_rdy", {31'd0, bus3.mem_ready}, 32'h1);

        drive(1, 1'b0, 3'b010, 32'h00001000, 32'h0);
        repeat (4) step();
        check("miss3_dat", bus3.mem_dat_i, MISS_RD);
        check_err("miss3_err", 1, 1'b1);

        // Reset mid-wait on a pending write.
        drive(0, 1'b0, 3'b010, BASE, 32'h0);
        step();
        drive(1, 1'b1, 3'b010, 32'h80000040, 32'h0BADF00D);
        repeat (2) step();
        #2 rst = 1'b0;
        #2;
        check("mrst0_dat", bus0.mem_dat_i, 32'h0);
        check("mrst0_rdy", {31'd0, bus0.mem_ready}, 32'h0);
        check("mrst3_dat", bus3.mem_dat_i, 32'h0);
        check("mrst3_rdy", {31'd0, bus3.mem_ready}, 32'h0);
        check_err("mrst3_err", 1, 1'b0);
        drive(1, 1'b0, 3'b010, 32'h80000040, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        step();
        check("post_rst0_rdy", {31'd0, bus0.mem_ready}, 32'h1);
        check("post_rst0_dat", bus0.mem_dat_i, mdl[0][0]);
        check("post_rst3_low", {31'd0, bus3.mem_ready}, 32'h0);
        repeat (3) step();
        check("post_rst3_rdy", {31'd0, bus3.mem_ready}, 32'h1);
        check("post_rst3_dat", bus3.mem_dat_i, mdl[1][16]);

        scratch = '0;
        if (scratch != 32'h0) $display("unexpected scratch");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
